// File: rtl/uart_rx_tx.sv
// Full-duplex 8N1 UART: independent receiver and transmitter on one clock.
// RX samples mid-bit through a 2-flop synchroniser; TX drives a registered line.
module uart_rx_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx,
    output logic       tx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_cpb_check
            $error("uart_rx_tx: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // ---------------- receiver ----------------
    logic             rx_s1;
    logic             rxs;
    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic [7:0]       rx_data_n;
    logic             rx_valid_n;
    logic             rx_err_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rxs   <= rx_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_state     <= rx_state_n;
            rx_cnt       <= rx_cnt_n;
            rx_bit       <= rx_bit_n;
            rx_shift     <= rx_shift_n;
            rx_data      <= rx_data_n;
            rx_valid     <= rx_valid_n;
            rx_frame_err <= rx_err_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        rx_err_n   = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                rx_bit_n = '0;
                if (!rxs) begin
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                // mid-start-bit check rejects short glitches
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rxs, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 1'b1;
                    if (rx_bit == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    if (rxs) begin
                        rx_data_n  = rx_shift;
                        rx_valid_n = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_err_n   = 1'b1;
                        rx_state_n = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                // a held break must not look like a new start bit
                rx_cnt_n = '0;
                if (rxs) begin
                    rx_state_n = RX_IDLE;
                end
            end
            default: begin
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    // ---------------- transmitter ----------------
    tx_state_t        tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             tx_n;
    logic             tx_busy_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx       <= tx_n;
            tx_busy  <= tx_busy_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_n       = tx;
        tx_busy_n  = tx_busy;
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_n  = '0;
                tx_bit_n  = '0;
                tx_n      = 1'b1;
                tx_busy_n = 1'b0;
                if (tx_start) begin
                    tx_shift_n = tx_data;
                    tx_n       = 1'b0;
                    tx_busy_n  = 1'b1;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_n       = tx_shift[0];
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_n       = 1'b1;
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_bit_n   = tx_bit + 1'b1;
                        tx_shift_n = tx_shift >> 1;
                        tx_n       = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_busy_n  = 1'b0;
                    tx_state_n = TX_IDLE;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_tx.sv
// Bench for uart_rx_tx: randomized frames, scoreboard queues and
// line-level monitors for both directions.
module tb_uart_rx_tx;

    localparam int CPB = 10;

    logic       clk;
    logic       rst;
    logic       rx_line;
    logic       rx_drv;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx;
    logic       tx_busy;
    bit         loopback;

    int n_chk;
    int n_pass;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    int         exp_err;
    logic [7:0] last_good;

    assign rx_line = loopback ? tx : rx_drv;

    uart_rx_tx #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx_line),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx          (tx),
        .tx_busy     (tx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one serial frame on rx: start, 8 data LSB first, stop.
    task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        if (stop_ok) exp_rx.push_back(b);
        else exp_err++;
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            step(CPB);
        end
        rx_drv = 1'b1;
        step(2);
    endtask

    // Request one byte; waits for the transmitter to free up first.
    task automatic tx_send(input logic [7:0] b, input bit hold);
        int n;
        n = 0;
        while (tx_busy && n < 2000) begin
            step(1);
            n++;
        end
        if (n >= 2000) chk("tx_idle_timeout", 32'(n), 0);
        tx_data  = b;
        tx_start = 1'b1;
        exp_tx.push_back(b);
        if (loopback) exp_rx.push_back(b);
        step(1);
        chk("tx_accept", 32'(tx_busy), 1);
        if (!hold) tx_start = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (tx_busy && n < 2000) begin
            step(1);
            n++;
        end
        if (n >= 2000) chk("tx_done_timeout", 32'(n), 0);
    endtask

    // RX scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid || rx_frame_err) begin
                chk("rx_exclusive", 32'(rx_valid & rx_frame_err), 0);
            end
            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    chk("rx_valid_unexpected", 32'(rx_valid), 0);
                end else begin
                    last_good = exp_rx.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(last_good));
                end
            end
            if (rx_frame_err) begin
                if (exp_err == 0) begin
                    chk("rx_err_unexpected", 32'(rx_frame_err), 0);
                end else begin
                    exp_err--;
                    chk("rx_err_keep", 32'(rx_data), 32'(last_good));
                end
            end
        end
    end

    // TX line monitor: every clock of the frame must hold the expected bit
    initial begin : tx_mon
        logic [9:0] f;
        logic [9:0] obs;
        bit         hold_ok;
        bit         abort;
        forever begin
            @(negedge clk);
            if (!rst && tx == 1'b0) begin
                if (exp_tx.size() == 0) begin
                    chk("tx_unexpected", 32'(tx), 1);
                    f = 10'h3ff;
                end else begin
                    f = {1'b1, exp_tx.pop_front(), 1'b0};
                end
                obs     = '0;
                hold_ok = 1'b1;
                abort   = 1'b0;
                for (int k = 0; k < 10 * CPB; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst) begin
                        abort = 1'b1;
                        break;
                    end
                    if (tx !== f[k / CPB]) hold_ok = 1'b0;
                    if (k % CPB == CPB / 2) obs[k / CPB] = tx;
                end
                if (!abort) begin
                    chk("tx_wave", 32'(obs), 32'(f));
                    chk("tx_bit_hold", 32'(hold_ok), 1);
                end
            end
        end
    end

    // busy must last exactly ten bit times per completed frame
    initial begin : busy_mon
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else if (tx_busy) begin
                run++;
            end else if (run > 0) begin
                chk("tx_busy_len", 32'(run), 32'(10 * CPB));
                run = 0;
            end
        end
    end

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        exp_err   = 0;
        last_good = 8'h00;
        loopback  = 1'b0;
        rst       = 1'b1;
        rx_drv    = 1'b1;
        tx_data   = 8'h00;
        tx_start  = 1'b0;
        step(3);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_tx_busy", 32'(tx_busy), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_err", 32'(rx_frame_err), 0);
        rst = 1'b0;
        step(5);

        rx_frame(8'hA5, 1'b1);
        step(5);

        tx_send(8'h3C, 1'b0);
        step(10 * CPB + 5);

        loopback = 1'b1;
        tx_send(8'h00, 1'b1);
        tx_send(8'hFF, 1'b1);
        tx_send(8'h55, 1'b0);
        wait_tx_idle();
        step(30);

        for (int i = 0; i < 5; i++) begin
            tx_send(8'($urandom), (i != 4));
        end
        wait_tx_idle();
        step(30);
        loopback = 1'b0;

        for (int i = 0; i < 4; i++) begin
            fork
                rx_frame(8'($urandom), 1'b1);
                tx_send(8'($urandom), 1'b0);
            join
            wait_tx_idle();
            step($urandom_range(1, 7));
        end

        rx_drv = 1'b0;
        step(3);
        rx_drv = 1'b1;
        step(30);

        rx_frame(8'h81, 1'b0);
        step(20);
        chk("err_rx_data_kept", 32'(rx_data), 32'(last_good));
        rx_frame(8'h12, 1'b1);
        step(5);

        tx_send(8'hC3, 1'b0);
        begin : mid_rx
            logic [9:0] f;
            f = {1'b1, 8'h9A, 1'b0};
            for (int i = 0; i < 5; i++) begin
                rx_drv = f[i];
                step(CPB);
            end
        end
        step(4);
        rst = 1'b1;
        #1;
        chk("arst_tx", 32'(tx), 1);
        chk("arst_tx_busy", 32'(tx_busy), 0);
        chk("arst_rx_valid", 32'(rx_valid), 0);
        chk("arst_rx_data", 32'(rx_data), 0);
        exp_tx.delete();
        exp_rx.delete();
        last_good = 8'h00;
        rx_drv    = 1'b1;
        step(3);
        rst = 1'b0;
        step(5);

        fork
            rx_frame(8'($urandom), 1'b1);
            tx_send(8'($urandom), 1'b0);
        join
        wait_tx_idle();
        step(200);

        chk("rx_pending", 32'(exp_rx.size()), 0);
        chk("tx_pending", 32'(exp_tx.size()), 0);
        chk("err_pending", 32'(exp_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
